// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one serial sequence detector among NREQ requesters.
// Frames are shifted MSB-first; the hit count is returned tagged with the requester index.
module seq_det_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CNTW  = 4,
  localparam int IDW  = $clog2(NREQ),
  localparam int BW   = $clog2(WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         gnt,
  output logic                    det_clr,
  output logic                    det_vld,
  output logic                    det_din,
  input  logic                    det_hit,
  output logic                    done,
  output logic [IDW-1:0]          done_id,
  output logic [CNTW-1:0]         match_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t            state, state_nx;
  logic [IDW-1:0]    ptr, idx, sel_idx, cand;
  logic              sel_found;
  logic [WIDTH-1:0]  frame, sel_data;
  logic [BW-1:0]     bitidx;
  logic [CNTW-1:0]   cnt, cnt_nx;

  // Search starts just above the last-served index, so it gets lowest priority.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IDW'((32'(ptr) + i) % 32'(NREQ));
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (sel_idx == IDW'(i)) sel_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    cnt_nx = cnt;
    if (det_hit && cnt != '1) cnt_nx = cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    gnt      = '0;
    det_clr  = 1'b0;
    det_vld  = 1'b0;
    det_din  = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  if (sel_found) state_nx = LOAD;
      LOAD: begin
        gnt[idx] = 1'b1;
        det_clr  = 1'b1;
        state_nx = SHIFT;
      end
      SHIFT: begin
        det_vld = 1'b1;
        det_din = frame[bitidx];
        if (bitidx == '0) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Result is registered on the bit-0 cycle so it is already valid during DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= IDW'(NREQ - 1);
      idx       <= '0;
      frame     <= '0;
      bitidx    <= '0;
      cnt       <= '0;
      match_cnt <= '0;
      done_id   <= '0;
    end else begin
      case (state)
        IDLE: if (sel_found) begin
          idx   <= sel_idx;
          ptr   <= sel_idx;
          frame <= sel_data;
        end
        LOAD: begin
          cnt    <= '0;
          bitidx <= BW'(WIDTH - 1);
        end
        SHIFT: begin
          cnt    <= cnt_nx;
          bitidx <= bitidx - 1'b1;
          if (bitidx == '0) begin
            match_cnt <= cnt_nx;
            done_id   <= idx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_det_sched.md
Name: seq_det_sched

Overview:
- Round-robin scheduler that shares one serial sequence-detector instance among NREQ requesters.
- Each requester presents a parallel WIDTH-bit frame. The block grants one requester, clears the detector, and shifts the frame MSB-first into it.
- It counts detector hits over the frame and returns the count tagged with the requester index.
- Sits between the requester blocks and the shared detector.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, frame length in bits (>=4).
- CNTW, 4, match-count width; must satisfy 2^CNTW-1 >= WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  request per requester; held high with stable data until its gnt bit pulses.
- req_data  in  NREQ*WIDTH  frame of requester i at bits [i*WIDTH +: WIDTH].
- gnt  out  NREQ  one-hot, one-cycle grant pulse; the frame is captured in this cycle.
- det_clr  out  1  synchronous clear to the detector (returns it to its initial state).
- det_vld  out  1  det_din is valid this cycle; the detector advances on this edge.
- det_din  out  1  serial frame bit.
- det_hit  in  1  detector hit for the current det_din; combinational from detector state and det_din.
- done  out  1  one-cycle result-valid pulse.
- done_id  out  $clog2(NREQ)  index of the requester whose result is on match_cnt.
- match_cnt  out  CNTW  number of hits in the frame; held until the next done.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - gnt, det_clr, det_vld, det_din, done = 0.
  - match_cnt=0, done_id=0.
  - Round-robin pointer = NREQ-1, so req[0] has first priority.
- States: IDLE, LOAD, SHIFT, DONE. All outputs are registered or decoded from state only; there is no combinational path from req to gnt.
- IDLE:
  - If any req bit is set, select the first set bit searching from ptr+1 upward with wrap-around.
  - Latch req_data of the selected requester and its index; set ptr to that index; go to LOAD.
  - If no req bit is set, stay in IDLE.
- LOAD (1 cycle): gnt[idx]=1 and det_clr=1. Internal hit counter cleared; bit index = WIDTH-1. Go to SHIFT.
- SHIFT (exactly WIDTH cycles):
  - det_vld=1, det_din = frame[bit index].
  - Each cycle, if det_hit=1, increment the counter, saturating at 2^CNTW-1.
  - Decrement the bit index; after the bit-0 cycle go to DONE.
- DONE (1 cycle): done=1; match_cnt = final count (including the bit-0 hit); done_id=idx. Go to IDLE.
- Latency: if gnt is in cycle T, det_vld covers T+1..T+WIDTH and done is in T+WIDTH+1. Minimum spacing between consecutive grants is WIDTH+3 cycles.
- det_hit is ignored whenever det_vld=0.
- Requests arriving while the block is not in IDLE are not lost: the requester keeps req high.
- A requester that drops req before being granted is simply skipped.
- Data changes after the gnt cycle do not affect the frame in flight.
- Fairness: the just-served requester has lowest priority in the next arbitration. Continuous requests from all NREQ requesters are served in cyclic order 0,1,..,NREQ-1,0.
- Simultaneous req bits when ptr=NREQ-1 are served lowest index first.
- Reset mid-frame: everything returns to reset values immediately. No done for the aborted frame. Detector outputs are left at 0; the next frame's det_clr re-initialises the detector.
- Unused/illegal state encodings recover to IDLE.

Test Plan:
- Bench pairs the block with a behavioural detector for overlapping pattern 1101 (hit when the current bit completes 1101).
- Single req[0], data 0xDB, WIDTH=8:
  - gnt=0001 in cycle T; det_clr in T.
  - det_din = 1,1,0,1,1,0,1,1 in T+1..T+8.
  - Hits on bits 4 and 7 → done at T+9, match_cnt=2, done_id=0.
- req[2] with 0x00, then a separate request with 0xFF → match_cnt=0 both times; det_vld high exactly 8 cycles per frame.
- All four req high continuously, all data 0xDD → gnt order 0,1,2,3,0; each done has match_cnt=2 with the matching done_id; grants spaced exactly 11 cycles apart.
- req[1] and req[3] asserted together right after req[1] was served → req[3] is granted first.
- rst pulsed low during SHIFT bit 3 → all outputs 0 at once, no done; after release, the pending req[0] is re-granted with a fresh det_clr and the full 8-bit frame.
- req[2] raised during SHIFT and its data changed after its gnt → it is granted only in the cycle after the previous frame's done-plus-IDLE; its result reflects the data captured at gnt.
